rgb_pwm_driver: RTL and testbench

- Consumes the 24-bit `light` colour word produced by the lights selector.
- Turns the colour into three 8-bit PWM pin drives (red, green, blue) for the board RGB LED.
- Duty cycles change only at PWM frame boundaries, so the LED never glitches mid-frame.
- An optional linear fade steps each channel towards the requested colour, one step per frame.

---
 rtl/lights_pkg.sv | 44 ++++
 rtl/pwm_channel.sv | 41 ++++
 rtl/rgb_pwm_driver.sv | 131 +++++++++++++
 tb/tb_rgb_pwm_driver.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lights_pkg.sv
// Shared constants, state encoding and fade helper for the RGB LED lights path.
// Colour words are packed red [23:16], green [15:8], blue [7:0].
package lights_pkg;

    localparam int RED_MSB = 23;
    localparam int RED_LSB = 16;
    localparam int GRN_MSB = 15;
    localparam int GRN_LSB = 8;
    localparam int BLU_MSB = 7;
    localparam int BLU_LSB = 0;

    // Last pwm_cnt value of a frame: 255 ticks per frame, so duty 255 is solid on.
    localparam logic [7:0] PWM_TOP = 8'd254;

    localparam logic [23:0] WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BLUE    = 24'h0000FF;
    localparam logic [23:0] GREEN   = 24'h00FF00;
    localparam logic [23:0] CYAN    = 24'h00FFFF;
    localparam logic [23:0] RED     = 24'hFF0000;
    localparam logic [23:0] MAGENTA = 24'hFF00FF;
    localparam logic [23:0] YELLOW  = 24'hFFFF00;
    localparam logic [23:0] OFF     = 24'h000000;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        FADING = 1'b1
    } fade_state_t;

    // One fade step of duty towards target, clamped so it lands exactly on target.
    function automatic logic [7:0] fade_toward(input logic [7:0] duty,
                                               input logic [7:0] target,
                                               input logic [8:0] step);
        logic [8:0] d9;
        logic [8:0] t9;
        d9 = {1'b0, duty};
        t9 = {1'b0, target};
        if (t9 >= d9) begin
            return ((t9 - d9) > step) ? 8'(d9 + step) : target;
        end else begin
            return ((d9 - t9) > step) ? 8'(d9 - step) : target;
        end
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One colour channel: holds the live duty, applies the fade step at frame
// boundaries and drives the registered PWM compare output.
module pwm_channel
    import lights_pkg::*;
#(
    parameter int FADE_STEP = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       boundary,
    input  logic [7:0] target,
    input  logic [7:0] pwm_cnt,
    output logic       pwm_out,
    output logic [7:0] duty,
    output logic [7:0] duty_next
);

    // Steps wider than the duty range behave like a straight jump.
    localparam logic [8:0] STEP9 = (FADE_STEP > 255) ? 9'd255 : 9'(FADE_STEP);

    always_comb begin
        duty_next = target;
        if (FADE_STEP != 0) begin
            duty_next = fade_toward(duty, target, STEP9);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty    <= 8'd0;
            pwm_out <= 1'b0;
        end else begin
            if (boundary) begin
                duty <= duty_next;
            end
            pwm_out <= enable & (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Drives the board RGB LED from a 24-bit colour word with glitch-free,
// frame-aligned duty updates and an optional per-frame linear fade.
module rgb_pwm_driver
    import lights_pkg::*;
#(
    parameter int PRESCALE  = 1,
    parameter int FADE_STEP = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] light,
    output logic        r_out,
    output logic        g_out,
    output logic        b_out,
    output logic        frame_start,
    output logic        busy
);

    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("rgb_pwm_driver: PRESCALE must be in 1..65535");
    end

    if (FADE_STEP < 0) begin : g_bad_fade_step
        $error("rgb_pwm_driver: FADE_STEP must not be negative");
    end

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
    localparam bit          FADE_EN    = (FADE_STEP > 0);

    logic [15:0] presc_cnt;
    logic [7:0]  pwm_cnt;
    logic        tick;
    logic        boundary;
    fade_state_t state;

    logic [7:0] target_r, target_g, target_b;
    logic [7:0] duty_r, duty_g, duty_b;
    logic [7:0] next_r, next_g, next_b;
    logic       any_diff;
    logic       all_settled;

    assign target_r = light[RED_MSB:RED_LSB];
    assign target_g = light[GRN_MSB:GRN_LSB];
    assign target_b = light[BLU_MSB:BLU_LSB];

    assign tick     = (presc_cnt == PRESC_LAST);
    assign boundary = tick && (pwm_cnt == PWM_TOP);

    // any_diff looks at the duties before the update, all_settled at the duties after it.
    assign any_diff    = (duty_r != target_r) || (duty_g != target_g) || (duty_b != target_b);
    assign all_settled = (next_r == target_r) && (next_g == target_g) && (next_b == target_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt   <= 16'd0;
            pwm_cnt     <= 8'd0;
            frame_start <= 1'b0;
        end else begin
            presc_cnt <= tick ? 16'd0 : presc_cnt + 16'd1;
            if (tick) begin
                pwm_cnt <= (pwm_cnt == PWM_TOP) ? 8'd0 : pwm_cnt + 8'd1;
            end
            frame_start <= boundary;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (FADE_EN && boundary && any_diff) begin
                        state <= FADING;
                        busy  <= 1'b1;
                    end
                end
                FADING: begin
                    // A new target mid-fade simply becomes the goal of the next steps.
                    if (boundary && all_settled) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    pwm_channel #(.FADE_STEP(FADE_STEP)) u_red (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .boundary  (boundary),
        .target    (target_r),
        .pwm_cnt   (pwm_cnt),
        .pwm_out   (r_out),
        .duty      (duty_r),
        .duty_next (next_r)
    );

    pwm_channel #(.FADE_STEP(FADE_STEP)) u_green (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .boundary  (boundary),
        .target    (target_g),
        .pwm_cnt   (pwm_cnt),
        .pwm_out   (g_out),
        .duty      (duty_g),
        .duty_next (next_g)
    );

    pwm_channel #(.FADE_STEP(FADE_STEP)) u_blue (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .boundary  (boundary),
        .target    (target_b),
        .pwm_cnt   (pwm_cnt),
        .pwm_out   (b_out),
        .duty      (duty_b),
        .duty_next (next_b)
    );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: four parameterisations share stimulus; a frame/tick
// arithmetic reference model predicts every output each cycle.
module tb_rgb_pwm_driver;
    import lights_pkg::*;

    localparam int NDUT = 4;
    localparam int P_TAB [NDUT] = '{1, 4, 1, 2};
    localparam int F_TAB [NDUT] = '{0, 0, 8, 37};

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [23:0] light;
    logic        r_o    [NDUT];
    logic        g_o    [NDUT];
    logic        b_o    [NDUT];
    logic        fs_o   [NDUT];
    logic        busy_o [NDUT];

    always #5 clk = ~clk;

    rgb_pwm_driver #(.PRESCALE(1), .FADE_STEP(0)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .light(light),
        .r_out(r_o[0]), .g_out(g_o[0]), .b_out(b_o[0]),
        .frame_start(fs_o[0]), .busy(busy_o[0])
    );
    rgb_pwm_driver #(.PRESCALE(4), .FADE_STEP(0)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .light(light),
        .r_out(r_o[1]), .g_out(g_o[1]), .b_out(b_o[1]),
        .frame_start(fs_o[1]), .busy(busy_o[1])
    );
    rgb_pwm_driver #(.PRESCALE(1), .FADE_STEP(8)) u_dut2 (
        .clk(clk), .rst(rst), .enable(enable), .light(light),
        .r_out(r_o[2]), .g_out(g_o[2]), .b_out(b_o[2]),
        .frame_start(fs_o[2]), .busy(busy_o[2])
    );
    rgb_pwm_driver #(.PRESCALE(2), .FADE_STEP(37)) u_dut3 (
        .clk(clk), .rst(rst), .enable(enable), .light(light),
        .r_out(r_o[3]), .g_out(g_o[3]), .b_out(b_o[3]),
        .frame_start(fs_o[3]), .busy(busy_o[3])
    );

    // Reference model state: clocks since reset release, duties, fade flag.
    int         n       [NDUT];
    int         duty    [NDUT][3];
    bit         fading  [NDUT];
    logic [4:0] exp_v   [NDUT];
    int         acc     [NDUT][3];
    int         last_hi [NDUT][3];
    int         last_fs [NDUT];
    int         fs_seen [NDUT];
    int         edge_cnt;
    int         total;
    int         bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Frame k covers clocks k*255*P .. (k+1)*255*P-1 after release; the tick
    // index is clocks/P and the pwm position is that index modulo 255.
    task automatic model_step();
        for (int d = 0; d < NDUT; d++) begin
            int p;
            int f;
            int pc;
            int tgt;
            bit bnd;
            bit any_diff;
            bit all_eq;
            logic [2:0] o;
            p = P_TAB[d];
            f = F_TAB[d];
            if (rst) begin
                n[d]      = 0;
                fading[d] = 1'b0;
                exp_v[d]  = '0;
                for (int c = 0; c < 3; c++) duty[d][c] = 0;
            end else begin
                pc = (n[d] / p) % 255;
                for (int c = 0; c < 3; c++) o[2-c] = enable && (pc < duty[d][c]);
                bnd = ((n[d] + 1) % (255 * p)) == 0;
                if (bnd) begin
                    any_diff = 1'b0;
                    all_eq   = 1'b1;
                    for (int c = 0; c < 3; c++) begin
                        tgt = int'((light >> (16 - 8 * c)) & 24'hFF);
                        if (duty[d][c] != tgt) any_diff = 1'b1;
                        if (f == 0) duty[d][c] = tgt;
                        else if (tgt > duty[d][c])
                            duty[d][c] += (tgt - duty[d][c] < f) ? tgt - duty[d][c] : f;
                        else
                            duty[d][c] -= (duty[d][c] - tgt < f) ? duty[d][c] - tgt : f;
                        if (duty[d][c] != tgt) all_eq = 1'b0;
                    end
                    if (f > 0) fading[d] = fading[d] ? !all_eq : any_diff;
                end
                exp_v[d] = {o, bnd, fading[d]};
                n[d]++;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        edge_cnt++;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d_cycle%0d", d, edge_cnt),
                  {r_o[d], g_o[d], b_o[d], fs_o[d], busy_o[d]}, exp_v[d]);
            if (rst) begin
                last_fs[d] = -1;
                for (int c = 0; c < 3; c++) acc[d][c] = 0;
            end else begin
                acc[d][0] += int'(r_o[d]);
                acc[d][1] += int'(g_o[d]);
                acc[d][2] += int'(b_o[d]);
                if (exp_v[d][1]) begin
                    for (int c = 0; c < 3; c++) begin
                        last_hi[d][c] = acc[d][c];
                        acc[d][c]     = 0;
                    end
                end
                if (fs_o[d]) begin
                    fs_seen[d]++;
                    if (last_fs[d] >= 0)
                        check($sformatf("fs_gap_d%0d", d), edge_cnt - last_fs[d], 255 * P_TAB[d]);
                    last_fs[d] = edge_cnt;
                end
            end
        end
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic do_reset(input int k);
        rst = 1'b1;
        run(k);
        rst = 1'b0;
    endtask

    initial begin
        int s;
        total    = 0;
        bad      = 0;
        edge_cnt = 0;
        rst      = 1'b1;
        enable   = 1'b1;
        light    = OFF;
        for (int d = 0; d < NDUT; d++) begin
            last_fs[d] = -1;
            fs_seen[d] = 0;
            for (int c = 0; c < 3; c++) begin
                acc[d][c]     = 0;
                last_hi[d][c] = 0;
            end
        end

        do_reset(2);
        check("reset_state_d0", {r_o[0], g_o[0], b_o[0], fs_o[0], busy_o[0]}, 5'b0);

        // Static white then blue, one clock per tick.
        light = WHITE;
        run(510);
        check("white_r_hi", last_hi[0][0], 255);
        check("white_g_hi", last_hi[0][1], 255);
        check("white_b_hi", last_hi[0][2], 255);
        light = BLUE;
        run(510);
        check("blue_r_hi", last_hi[0][0], 0);
        check("blue_g_hi", last_hi[0][1], 0);
        check("blue_b_hi", last_hi[0][2], 255);

        // Duty measurement.
        light = 24'h804000;
        run(510);
        check("duty_r_hi", last_hi[0][0], 128);
        check("duty_g_hi", last_hi[0][1], 64);
        check("duty_b_hi", last_hi[0][2], 0);

        // Mid-frame change with PRESCALE=4: switch at pwm_cnt=100 of frame two.
        do_reset(2);
        light = GREEN;
        run(1420);
        light = RED;
        run(620);
        check("presc_green_frame_g", last_hi[1][1], 1020);
        check("presc_green_frame_r", last_hi[1][0], 0);
        run(1020);
        check("presc_red_frame_r", last_hi[1][0], 1020);
        check("presc_red_frame_g", last_hi[1][1], 0);

        // Fade 0 -> 20 in steps of 8.
        do_reset(2);
        light = 24'h000014;
        run(255);
        check("fade_busy_b1", busy_o[2], 1'b1);
        run(255);
        check("fade_duty8", last_hi[2][2], 8);
        check("fade_busy_b2", busy_o[2], 1'b1);
        run(255);
        check("fade_duty16", last_hi[2][2], 16);
        check("fade_busy_b3", busy_o[2], 1'b0);
        run(255);
        check("fade_duty20", last_hi[2][2], 20);

        // Reset in the middle of a fade.
        do_reset(2);
        light = 24'h000014;
        run(300);
        check("busy_before_rst", busy_o[2], 1'b1);
        rst = 1'b1;
        run(1);
        check("rst_mid_fade_zero", {r_o[2], g_o[2], b_o[2], fs_o[2], busy_o[2]}, 5'b0);
        run(1);
        rst = 1'b0;
        run(254);
        check("no_fs_before_255", fs_o[0], 1'b0);
        run(1);
        check("fs_at_255", fs_o[0], 1'b1);

        // Enable gate.
        light = WHITE;
        run(600);
        check("en_outputs_high", {r_o[0], g_o[0], b_o[0]}, 3'b111);
        enable = 1'b0;
        run(1);
        check("en_low_outputs", {r_o[0], g_o[0], b_o[0]}, 3'b000);
        s = fs_seen[0];
        run(300);
        check("en_low_fs_count", fs_seen[0] - s, 1);
        enable = 1'b1;
        run(1);
        check("en_restore_outputs", {r_o[0], g_o[0], b_o[0]}, 3'b111);

        // Randomised traffic: colour changes, enable drops, occasional reset.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                case ($urandom_range(0, 3))
                    0:       light = CYAN;
                    1:       light = MAGENTA;
                    2:       light = YELLOW;
                    default: light = 24'($urandom);
                endcase
            end
            enable = ($urandom_range(0, 19) != 0);
            rst    = ($urandom_range(0, 1499) == 0);
            cycle();
        end
        rst = 1'b0;
        run(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
